// File: rtl/spwm_pkg.sv
// rtl/spwm_pkg.sv - shared FSM/quadrant types and the 65-entry quarter-wave sine table for the SPWM duty sequencer
package spwm_pkg;

    localparam int QSTEPS_DEF = 64;
    localparam int TAB_N      = 65;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_SCALE  = 2'd2,
        ST_OUT    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    // round(65535*sin(pi/2*i/64)); coarser QSTEPS values stride through it
    localparam logic [15:0] SIN_TAB [0:TAB_N-1] = '{
        16'd0,     16'd1608,  16'd3216,  16'd4821,  16'd6424,  16'd8022,  16'd9616,  16'd11204,
        16'd12785, 16'd14359, 16'd15924, 16'd17479, 16'd19024, 16'd20557, 16'd22078, 16'd23586,
        16'd25079, 16'd26557, 16'd28020, 16'd29465, 16'd30893, 16'd32302, 16'd33692, 16'd35061,
        16'd36409, 16'd37736, 16'd39039, 16'd40319, 16'd41575, 16'd42806, 16'd44011, 16'd45189,
        16'd46340, 16'd47464, 16'd48558, 16'd49624, 16'd50659, 16'd51664, 16'd52638, 16'd53580,
        16'd54490, 16'd55367, 16'd56211, 16'd57021, 16'd57797, 16'd58537, 16'd59243, 16'd59913,
        16'd60546, 16'd61144, 16'd61704, 16'd62227, 16'd62713, 16'd63161, 16'd63571, 16'd63943,
        16'd64276, 16'd64570, 16'd64826, 16'd65042, 16'd65219, 16'd65357, 16'd65456, 16'd65515,
        16'd65535
    };

    function automatic logic quad_is_mirrored(input quad_e q);
        return (q == QUAD_1) || (q == QUAD_3);
    endfunction

    function automatic logic quad_is_negative(input quad_e q);
        return (q == QUAD_2) || (q == QUAD_3);
    endfunction

endpackage

// File: rtl/spwm_sin_rom.sv
// rtl/spwm_sin_rom.sv - registered quarter-wave sine ROM, address 0..QSTEPS inclusive
module spwm_sin_rom
    import spwm_pkg::*;
#(
    parameter int QSTEPS = QSTEPS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic [$clog2(QSTEPS):0]  addr_i,
    output logic [15:0]              data_o
);

    localparam logic [6:0] STRIDE = 7'((TAB_N - 1) / QSTEPS);

    logic [6:0]  tidx;
    logic [15:0] data_q;

    always_comb begin
        tidx = 7'(addr_i * STRIDE);
        if (tidx > 7'd64) begin
            tidx = 7'd64;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= 16'd0;
        end else if (en_i) begin
            data_q <= SIN_TAB[tidx];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/spwm_duty_seq.sv
// rtl/spwm_duty_seq.sv - sine-modulated duty sequencer for the SPWM generator; SPWM_DITHER_EN adds LFSR LSB dither
module spwm_duty_seq
    import spwm_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int PERIOD = 10000,
    parameter int QSTEPS = QSTEPS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_syn,
    input  logic             e,
    input  logic             step,
    input  logic [7:0]       amp,
    output logic [WIDTH-1:0] duty,
    output logic             duty_valid,
    output logic             zero_x,
    output logic [1:0]       quadrant,
    output logic             overrun
);

    localparam int          KW     = $clog2(QSTEPS);
    localparam int          IW     = KW + 2;
    localparam logic [15:0] HALF_W = 16'(PERIOD / 2);
    localparam logic [KW:0] QS_W   = (KW + 1)'(QSTEPS);

    state_e           state_q;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    idx_s_q;
    logic [7:0]       amp_q;
    logic [15:0]      off_q;
    logic [WIDTH-1:0] duty_q;
    logic             duty_valid_q;
    logic             zero_x_q;
    quad_e            quad_q;
    logic             overrun_q;
`ifdef SPWM_DITHER_EN
    logic [7:0]       lfsr_q;
`endif

    quad_e            q_s;
    logic [KW-1:0]    k_s;
    logic [KW:0]      rom_addr;
    logic [15:0]      rom_data;
    logic [23:0]      prod24;
    logic [15:0]      mag;
    logic [31:0]      prod32;
    logic [15:0]      off_d;
    logic [16:0]      base;
    logic [16:0]      sum;
    logic [WIDTH-1:0] duty_d;

    assign q_s = quad_e'(idx_s_q[IW-1 -: 2]);
    assign k_s = idx_s_q[KW-1:0];

    // Falling quadrants read the table backwards from the peak
    assign rom_addr = quad_is_mirrored(q_s) ? (QS_W - {1'b0, k_s}) : {1'b0, k_s};

    spwm_sin_rom #(
        .QSTEPS (QSTEPS)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .en_i   (e),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    always_comb begin
        prod24 = 24'(rom_data) * 24'(amp_q);
        mag    = 16'(prod24 >> 8);
        prod32 = 32'(mag) * 32'(HALF_W);
        off_d  = 16'(prod32 >> 16);
    end

    always_comb begin
`ifdef SPWM_DITHER_EN
        base = 17'(HALF_W) + 17'(lfsr_q[0]);
`else
        base = 17'(HALF_W);
`endif
        if (quad_is_negative(q_s)) begin
            sum = (base >= {1'b0, off_q}) ? (base - {1'b0, off_q}) : 17'd0;
        end else begin
            sum = base + {1'b0, off_q};
        end
        duty_d = (sum > 17'(PERIOD)) ? WIDTH'(PERIOD) : WIDTH'(sum);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            idx_s_q      <= '0;
            amp_q        <= 8'd0;
            off_q        <= 16'd0;
            duty_q       <= WIDTH'(PERIOD / 2);
            duty_valid_q <= 1'b0;
            zero_x_q     <= 1'b0;
            quad_q       <= QUAD_0;
            overrun_q    <= 1'b0;
`ifdef SPWM_DITHER_EN
            lfsr_q       <= 8'hA5;
`endif
        end else if (rst_syn) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            idx_s_q      <= '0;
            amp_q        <= 8'd0;
            off_q        <= 16'd0;
            duty_q       <= WIDTH'(PERIOD / 2);
            duty_valid_q <= 1'b0;
            zero_x_q     <= 1'b0;
            quad_q       <= QUAD_0;
            overrun_q    <= 1'b0;
`ifdef SPWM_DITHER_EN
            lfsr_q       <= 8'hA5;
`endif
        end else begin
            // Pulses stay single-cycle even if e drops right after an update
            duty_valid_q <= 1'b0;
            zero_x_q     <= 1'b0;
            if (e) begin
                case (state_q)
                    ST_IDLE: begin
                        if (step) begin
                            idx_s_q <= idx_q;
                            idx_q   <= idx_q + IW'(1);
                            if (idx_q == '0) begin
                                amp_q <= amp;
                            end
`ifdef SPWM_DITHER_EN
                            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
                            state_q <= ST_LOOKUP;
                        end
                    end
                    ST_LOOKUP: begin
                        state_q <= ST_SCALE;
                    end
                    ST_SCALE: begin
                        off_q   <= off_d;
                        state_q <= ST_OUT;
                    end
                    ST_OUT: begin
                        duty_q       <= duty_d;
                        duty_valid_q <= 1'b1;
                        zero_x_q     <= (idx_s_q == '0);
                        quad_q       <= q_s;
                        state_q      <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
                if (step && (state_q != ST_IDLE)) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign duty       = duty_q;
    assign duty_valid = duty_valid_q;
    assign zero_x     = zero_x_q;
    assign quadrant   = quad_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_spwm_duty_seq.sv
// tb/tb_spwm_duty_seq.sv - scoreboard bench for spwm_duty_seq with hand-computed duty values
`timescale 1ns/1ps
module tb_spwm_duty_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst_syn = 1'b0;
    logic        e = 1'b1;
    logic        step = 1'b0;
    logic [7:0]  amp = 8'd255;
    logic [13:0] duty;
    logic        duty_valid;
    logic        zero_x;
    logic [1:0]  quadrant;
    logic        overrun;

    typedef struct {
        bit chk;
        int duty;
        int zx;
        int quad;
    } exp_t;

    exp_t exq[$];
    exp_t mx;
    int   tests = 0;
    int   fails = 0;
    int   b_idx = 0;
    int   valid_seen = 0;
    int   vs;

    always #5 clk = ~clk;

    spwm_duty_seq dut (
        .clk        (clk),
        .rst        (rst),
        .rst_syn    (rst_syn),
        .e          (e),
        .step       (step),
        .amp        (amp),
        .duty       (duty),
        .duty_valid (duty_valid),
        .zero_x     (zero_x),
        .quadrant   (quadrant),
        .overrun    (overrun)
    );

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input bit chk, input int d);
        exq.push_back('{chk, d, (b_idx == 0) ? 1 : 0, b_idx / 64});
        b_idx = (b_idx + 1) % 256;
    endtask

    task automatic issue_step();
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
    endtask

    task automatic step_full(input bit chk, input int d);
        push_exp(chk, d);
        issue_step();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (duty_valid) begin
                valid_seen++;
                if (exq.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    mx = exq.pop_front();
                    if (mx.chk) check("duty", int'(duty), mx.duty);
                    check("zero_x", int'(zero_x), mx.zx);
                    check("quadrant", int'(quadrant), mx.quad);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at 500us, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_duty", int'(duty), 5000);
        check("rst_valid", int'(duty_valid), 0);
        check("rst_zero_x", int'(zero_x), 0);
        check("rst_quadrant", int'(quadrant), 0);
        check("rst_overrun", int'(overrun), 0);
        @(negedge clk) rst = 1'b1;

        // first sample and its latency
        push_exp(1, 5000);
        issue_step();
        @(negedge clk);
        @(negedge clk);
        check("latency_early", int'(duty_valid), 0);
        @(negedge clk);
        check("latency_on", int'(duty_valid), 1);

        // full-amplitude wave: idx1, peak, trough
        for (int i = 1; i < 256; i++) begin
            if (i == 1)        step_full(1, 5122);
            else if (i == 64)  step_full(1, 9980);
            else if (i == 192) step_full(1, 20);
            else               step_full(0, 0);
        end

        // amp=0 cycle, amp change mid-cycle takes effect at next idx 0
        amp = 8'd0;
        for (int i = 0; i < 256; i++) begin
            if (i == 100) amp = 8'd128;
            step_full(1, 5000);
        end
        for (int i = 0; i <= 64; i++) begin
            if (i == 0)       step_full(1, 5000);
            else if (i == 64) step_full(1, 7499);
            else              step_full(0, 0);
        end

        // overrun and synchronous clear
        amp = 8'd255;
        @(negedge clk) rst_syn = 1'b1;
        @(negedge clk) rst_syn = 1'b0;
        b_idx = 0;
        check("rst_syn_duty", int'(duty), 5000);
        push_exp(1, 5000);
        @(negedge clk) step = 1'b1;
        @(negedge clk);
        @(negedge clk) step = 1'b0;
        repeat (3) @(negedge clk);
        check("overrun_set", int'(overrun), 1);
        step_full(1, 5122);
        @(negedge clk) begin rst_syn = 1'b1; step = 1'b1; end
        @(negedge clk) begin rst_syn = 1'b0; step = 1'b0; end
        b_idx = 0;
        repeat (4) @(negedge clk);
        check("rst_syn_overrun", int'(overrun), 0);
        check("rst_syn_duty2", int'(duty), 5000);
        step_full(1, 5000);

        // enable stall during LOOKUP
        push_exp(1, 5122);
        @(negedge clk) step = 1'b1;
        @(negedge clk) begin step = 1'b0; e = 1'b0; end
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk) e = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_early", int'(duty_valid), 0);
        @(negedge clk);
        check("stall_on", int'(duty_valid), 1);
        check("stall_overrun", int'(overrun), 0);

        // async reset while in SCALE
        @(negedge clk) step = 1'b1;
        @(negedge clk);
        @(negedge clk) step = 1'b0;
        check("pre_rst_overrun", int'(overrun), 1);
        rst = 1'b0;
        #1;
        check("arst_duty", int'(duty), 5000);
        check("arst_valid", int'(duty_valid), 0);
        check("arst_zero_x", int'(zero_x), 0);
        check("arst_quadrant", int'(quadrant), 0);
        check("arst_overrun", int'(overrun), 0);
        b_idx = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vs = valid_seen;
        repeat (10) @(negedge clk);
        check("no_valid_after_rst", valid_seen - vs, 0);
        step_full(1, 5000);

        repeat (5) @(negedge clk);
        check("queue_drained", exq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
